// File: rtl/udp_wr_burst_gen.sv
// Turns UDP write-command packets into AXI-style write bursts. Payload is buffered
// in a first-word-fall-through FIFO so the receive side is never back-pressured.
module udp_wr_burst_gen #(
  parameter int         FIFO_DEPTH = 256,
  parameter logic [3:0] WR_OPCODE  = 4'h1
) (
  input  logic        gmii_rx_clk,
  input  logic        rstn,
  input  logic        rec_en,
  input  logic [31:0] udp_rx_data,
  input  logic        rec_pkt_done,
  output logic [27:0] wr_addr,
  output logic [7:0]  wr_len,
  output logic        wr_addr_valid,
  input  logic        wr_addr_ready,
  output logic [31:0] wr_data,
  output logic [3:0]  wr_strb,
  output logic        wr_data_valid,
  input  logic        wr_data_ready,
  output logic        wr_data_last,
  output logic        busy,
  output logic [15:0] err_short,
  output logic [15:0] drop_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {RX_IDLE, RX_ADDR, RX_DATA, RX_DISCARD} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_AW, TX_W} tx_state_t;

  rx_state_t   rx_state_q, rx_state_d;
  tx_state_t   tx_state_q, tx_state_d;
  logic [7:0]  len_q, len_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [8:0]  beat_q, beat_d;
  logic        busy_q, busy_d;
  logic        pad_q, pad_d;
  logic [15:0] err_short_q, err_short_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [27:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_len_q, wr_len_d;
  logic        wr_addr_valid_q, wr_addr_valid_d;
  logic [PW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [31:0] mem [FIFO_DEPTH];

  logic       fifo_empty, fifo_full, push, pop, w_valid, w_fire, w_last;
  logic [8:0] cnt_after;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign push       = (rx_state_q == RX_DATA) && rec_en && (cnt_q <= {1'b0, len_q});
  assign w_valid    = (tx_state_q == TX_W) && (!fifo_empty || pad_q);
  assign w_fire     = w_valid && wr_data_ready;
  assign pop        = w_fire && !fifo_empty;
  assign w_last     = (beat_q == {1'b0, wr_len_q});
  // A word arriving with rec_pkt_done is counted before the short-packet check.
  assign cnt_after  = cnt_q + {8'd0, push};

  always_comb begin
    rx_state_d      = rx_state_q;
    tx_state_d      = tx_state_q;
    len_d           = len_q;
    cnt_d           = cnt_q;
    beat_d          = beat_q;
    busy_d          = busy_q;
    pad_d           = pad_q;
    err_short_d     = err_short_q;
    drop_cnt_d      = drop_cnt_q;
    wr_addr_d       = wr_addr_q;
    wr_len_d        = wr_len_q;
    wr_addr_valid_d = wr_addr_valid_q;
    wptr_d          = wptr_q + {{PW{1'b0}}, push};
    rptr_d          = rptr_q + {{PW{1'b0}}, pop};

    case (rx_state_q)
      RX_IDLE: begin
        if (rec_en) begin
          if (busy_q) begin
            rx_state_d = RX_DISCARD;
            drop_cnt_d = sat_inc(drop_cnt_q);
          end else if (udp_rx_data[31:28] != WR_OPCODE) begin
            rx_state_d = RX_DISCARD;
          end else begin
            len_d      = udp_rx_data[7:0];
            rx_state_d = RX_ADDR;
            if (rec_pkt_done) err_short_d = sat_inc(err_short_q);
          end
        end
      end
      RX_ADDR: begin
        if (rec_en) begin
          wr_addr_d       = udp_rx_data[27:0];
          wr_len_d        = len_q;
          wr_addr_valid_d = 1'b1;
          tx_state_d      = TX_AW;
          busy_d          = 1'b1;
          cnt_d           = 9'd0;
          rx_state_d      = RX_DATA;
        end
        if (rec_pkt_done) begin
          err_short_d = sat_inc(err_short_q);
          if (rec_en) pad_d = 1'b1;
        end
      end
      RX_DATA: begin
        cnt_d = cnt_after;
        if (rec_pkt_done && (cnt_after < ({1'b0, len_q} + 9'd1))) begin
          pad_d       = 1'b1;
          err_short_d = sat_inc(err_short_q);
        end
      end
      default: ;
    endcase
    if (rec_pkt_done) rx_state_d = RX_IDLE;

    case (tx_state_q)
      TX_AW: begin
        if (wr_addr_valid_q && wr_addr_ready) begin
          wr_addr_valid_d = 1'b0;
          beat_d          = 9'd0;
          tx_state_d      = TX_W;
        end
      end
      TX_W: begin
        if (w_fire) begin
          beat_d = beat_q + 9'd1;
          if (w_last) begin
            tx_state_d = TX_IDLE;
            busy_d     = 1'b0;
            pad_d      = 1'b0;
            beat_d     = 9'd0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge gmii_rx_clk or negedge rstn) begin
    if (!rstn) begin
      rx_state_q      <= RX_IDLE;
      tx_state_q      <= TX_IDLE;
      len_q           <= '0;
      cnt_q           <= '0;
      beat_q          <= '0;
      busy_q          <= 1'b0;
      pad_q           <= 1'b0;
      err_short_q     <= '0;
      drop_cnt_q      <= '0;
      wr_addr_q       <= '0;
      wr_len_q        <= '0;
      wr_addr_valid_q <= 1'b0;
      wptr_q          <= '0;
      rptr_q          <= '0;
    end else begin
      rx_state_q      <= rx_state_d;
      tx_state_q      <= tx_state_d;
      len_q           <= len_d;
      cnt_q           <= cnt_d;
      beat_q          <= beat_d;
      busy_q          <= busy_d;
      pad_q           <= pad_d;
      err_short_q     <= err_short_d;
      drop_cnt_q      <= drop_cnt_d;
      wr_addr_q       <= wr_addr_d;
      wr_len_q        <= wr_len_d;
      wr_addr_valid_q <= wr_addr_valid_d;
      wptr_q          <= wptr_d;
      rptr_q          <= rptr_d;
    end
  end

  always_ff @(posedge gmii_rx_clk) begin
    if (push) mem[wptr_q[PW-1:0]] <= udp_rx_data;
  end

  // One packet never exceeds the FIFO, so a full push means a sizing error.
  assert property (@(posedge gmii_rx_clk) disable iff (!rstn) !(push && fifo_full));

  assign wr_addr       = wr_addr_q;
  assign wr_len        = wr_len_q;
  assign wr_addr_valid = wr_addr_valid_q;
  assign wr_data       = fifo_empty ? 32'd0 : mem[rptr_q[PW-1:0]];
  assign wr_strb       = fifo_empty ? 4'h0 : 4'hF;
  assign wr_data_valid = w_valid;
  assign wr_data_last  = w_valid && w_last;
  assign busy          = busy_q;
  assign err_short     = err_short_q;
  assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_udp_wr_burst_gen.sv
// Directed self-checking bench for udp_wr_burst_gen: one task per scenario,
// beats and AW handshakes collected on the falling edge.
module tb_udp_wr_burst_gen;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rec_en = 1'b0;
  logic [31:0] udp_rx_data = 32'd0;
  logic        rec_pkt_done = 1'b0;
  logic [27:0] wr_addr;
  logic [7:0]  wr_len;
  logic        wr_addr_valid;
  logic        wr_addr_ready = 1'b0;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        wr_data_valid;
  logic        wr_data_ready = 1'b0;
  logic        wr_data_last;
  logic        busy;
  logic [15:0] err_short;
  logic [15:0] drop_cnt;

  int assertions = 0;
  int failures   = 0;
  int stall_viol = 0;
  int w_mode     = 0;
  int aw_mode    = 0;

  logic [31:0] bd_q[$];
  logic [3:0]  bs_q[$];
  logic        bl_q[$];
  logic [27:0] aa_q[$];
  logic [7:0]  al_q[$];

  udp_wr_burst_gen #(.FIFO_DEPTH(256), .WR_OPCODE(4'h1)) dut (
    .gmii_rx_clk   (clk),
    .rstn          (rstn),
    .rec_en        (rec_en),
    .udp_rx_data   (udp_rx_data),
    .rec_pkt_done  (rec_pkt_done),
    .wr_addr       (wr_addr),
    .wr_len        (wr_len),
    .wr_addr_valid (wr_addr_valid),
    .wr_addr_ready (wr_addr_ready),
    .wr_data       (wr_data),
    .wr_strb       (wr_strb),
    .wr_data_valid (wr_data_valid),
    .wr_data_ready (wr_data_ready),
    .wr_data_last  (wr_data_last),
    .busy          (busy),
    .err_short     (err_short),
    .drop_cnt      (drop_cnt)
  );

  always #5 clk = ~clk;

  // Ready drivers: mode 0 = always high, 1 = random, 2 = held low.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      wr_data_ready = (w_mode == 0) ? 1'b1 : (w_mode == 1) ? ($urandom_range(0, 1) == 1) : 1'b0;
      wr_addr_ready = (aw_mode == 0) ? 1'b1 : (aw_mode == 1) ? ($urandom_range(0, 1) == 1) : 1'b0;
    end
  end

  // Records accepted beats/addresses and flags any valid that drops or changes while stalled.
  initial begin
    logic        hold_w, hold_a, h_last;
    logic [31:0] h_data;
    logic [3:0]  h_strb;
    logic [27:0] h_addr;
    logic [7:0]  h_len;
    hold_w = 1'b0;
    hold_a = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        hold_w = 1'b0;
        hold_a = 1'b0;
      end else begin
        if (hold_w && (!wr_data_valid || wr_data !== h_data || wr_strb !== h_strb || wr_data_last !== h_last))
          stall_viol++;
        if (hold_a && (!wr_addr_valid || wr_addr !== h_addr || wr_len !== h_len))
          stall_viol++;
        hold_w = wr_data_valid && !wr_data_ready;
        hold_a = wr_addr_valid && !wr_addr_ready;
        h_data = wr_data;
        h_strb = wr_strb;
        h_last = wr_data_last;
        h_addr = wr_addr;
        h_len  = wr_len;
        if (wr_data_valid && wr_data_ready) begin
          bd_q.push_back(wr_data);
          bs_q.push_back(wr_strb);
          bl_q.push_back(wr_data_last);
        end
        if (wr_addr_valid && wr_addr_ready) begin
          aa_q.push_back(wr_addr);
          al_q.push_back(wr_len);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clear_queues();
    bd_q.delete();
    bs_q.delete();
    bl_q.delete();
    aa_q.delete();
    al_q.delete();
  endtask

  task automatic send_word(input logic [31:0] w, input logic done);
    @(posedge clk);
    #1;
    rec_en       = 1'b1;
    udp_rx_data  = w;
    rec_pkt_done = done;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
    rec_en       = 1'b0;
    rec_pkt_done = 1'b0;
    udp_rx_data  = 32'd0;
  endtask

  task automatic send_pkt(input logic [3:0] op, input logic [7:0] len, input logic [27:0] addr,
                          input int nwords, input logic [31:0] base);
    send_word({op, 20'h0, len}, 1'b0);
    send_word({4'h0, addr}, nwords == 0);
    for (int i = 0; i < nwords; i++) send_word(base + 32'(i), i == nwords - 1);
    idle_cycle();
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    assertions++;
    if (busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL burst_timeout: busy=%b after %0d cycles, expected 0", busy, n);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    assertions++;
    if ({wr_addr_valid, wr_data_valid, wr_data_last, busy} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_flags: got %b, expected 0000", {wr_addr_valid, wr_data_valid, wr_data_last, busy});
    end
    assertions++;
    if (wr_addr !== 28'd0 || wr_len !== 8'd0 || wr_data !== 32'd0 || wr_strb !== 4'h0) begin
      failures++;
      $display("[TB] FAIL reset_data: got addr=%h len=%h data=%h strb=%h, expected all 0", wr_addr, wr_len, wr_data, wr_strb);
    end
    assertions++;
    if (err_short !== 16'd0 || drop_cnt !== 16'd0) begin
      failures++;
      $display("[TB] FAIL reset_counters: got err_short=%0d drop_cnt=%0d, expected 0 0", err_short, drop_cnt);
    end
    @(posedge clk);
    #2 rstn = 1'b1;
  endtask

  task automatic test_basic();
    clear_queues();
    w_mode = 0;
    aw_mode = 0;
    send_word({4'h1, 20'h0, 8'd3}, 1'b0);
    send_word(32'h0000_0100, 1'b0);
    @(negedge clk);
    assertions++;
    if (wr_addr_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_aw_early: got valid=%b, expected 0", wr_addr_valid);
    end
    send_word(32'd1, 1'b0);
    @(negedge clk);
    assertions++;
    if (wr_addr_valid !== 1'b1 || busy !== 1'b1 || wr_addr !== 28'h100 || wr_len !== 8'd3) begin
      failures++;
      $display("[TB] FAIL basic_aw: got valid=%b busy=%b addr=%h len=%0d, expected 1 1 0000100 3",
               wr_addr_valid, busy, wr_addr, wr_len);
    end
    send_word(32'd2, 1'b0);
    send_word(32'd3, 1'b0);
    send_word(32'd4, 1'b1);
    idle_cycle();
    wait_done(100);
    assertions++;
    if (aa_q.size() != 1 || bd_q.size() != 4) begin
      failures++;
      $display("[TB] FAIL basic_counts: got aw=%0d beats=%0d, expected 1 4", aa_q.size(), bd_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      assertions++;
      if (i >= bd_q.size() || bd_q[i] !== 32'(i + 1) || bs_q[i] !== 4'hF || bl_q[i] !== (i == 3)) begin
        failures++;
        $display("[TB] FAIL basic_beat%0d: got data=%h strb=%h last=%b, expected data=%h strb=f last=%b",
                 i, bd_q[i], bs_q[i], bl_q[i], 32'(i + 1), (i == 3));
      end
    end
  endtask

  task automatic test_stall();
    clear_queues();
    stall_viol = 0;
    w_mode = 1;
    aw_mode = 1;
    send_pkt(4'h1, 8'd255, 28'h0ABCDE0, 256, 32'hA500_0000);
    wait_done(3000);
    w_mode = 0;
    aw_mode = 0;
    assertions++;
    if (aa_q.size() != 1 || aa_q[0] !== 28'h0ABCDE0 || al_q[0] !== 8'd255) begin
      failures++;
      $display("[TB] FAIL stall_aw: got n=%0d addr=%h len=%0d, expected 1 0abcde0 255", aa_q.size(), aa_q[0], al_q[0]);
    end
    assertions++;
    if (bd_q.size() != 256) begin
      failures++;
      $display("[TB] FAIL stall_count: got %0d beats, expected 256", bd_q.size());
    end
    for (int i = 0; i < 256; i++) begin
      assertions++;
      if (i >= bd_q.size() || bd_q[i] !== 32'hA500_0000 + 32'(i) || bs_q[i] !== 4'hF || bl_q[i] !== (i == 255)) begin
        failures++;
        $display("[TB] FAIL stall_beat%0d: got data=%h strb=%h last=%b, expected data=%h strb=f last=%b",
                 i, bd_q[i], bs_q[i], bl_q[i], 32'hA500_0000 + 32'(i), (i == 255));
      end
    end
    assertions++;
    if (stall_viol != 0) begin
      failures++;
      $display("[TB] FAIL stall_hold: got %0d unstable stalled cycles, expected 0", stall_viol);
    end
  endtask

  task automatic test_short();
    clear_queues();
    send_pkt(4'h1, 8'd7, 28'h0000200, 3, 32'h0000_0C00);
    @(negedge clk);
    assertions++;
    if (err_short !== 16'd1) begin
      failures++;
      $display("[TB] FAIL short_err: got %0d, expected 1", err_short);
    end
    wait_done(100);
    assertions++;
    if (bd_q.size() != 8 || aa_q.size() != 1) begin
      failures++;
      $display("[TB] FAIL short_counts: got beats=%0d aw=%0d, expected 8 1", bd_q.size(), aa_q.size());
    end
    for (int i = 0; i < 8; i++) begin
      logic [31:0] ed;
      logic [3:0]  es;
      ed = (i < 3) ? 32'h0000_0C00 + 32'(i) : 32'd0;
      es = (i < 3) ? 4'hF : 4'h0;
      assertions++;
      if (i >= bd_q.size() || bd_q[i] !== ed || bs_q[i] !== es || bl_q[i] !== (i == 7)) begin
        failures++;
        $display("[TB] FAIL short_beat%0d: got data=%h strb=%h last=%b, expected data=%h strb=%h last=%b",
                 i, bd_q[i], bs_q[i], bl_q[i], ed, es, (i == 7));
      end
    end
  endtask

  task automatic test_long();
    clear_queues();
    send_pkt(4'h1, 8'd1, 28'h0000300, 5, 32'h0000_0D00);
    wait_done(100);
    repeat (3) @(negedge clk);
    assertions++;
    if (bd_q.size() != 2 || bd_q[0] !== 32'h0D00 || bd_q[1] !== 32'h0D01 || bl_q[0] !== 1'b0 || bl_q[1] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL long_beats: got n=%0d d0=%h d1=%h last=%b%b, expected 2 00000d00 00000d01 01",
               bd_q.size(), bd_q[0], bd_q[1], bl_q[0], bl_q[1]);
    end
    assertions++;
    if (err_short !== 16'd1) begin
      failures++;
      $display("[TB] FAIL long_err: got %0d, expected 1", err_short);
    end
    clear_queues();
    send_pkt(4'h1, 8'd2, 28'h0000310, 3, 32'h0000_0E00);
    wait_done(100);
    assertions++;
    if (aa_q.size() != 1 || aa_q[0] !== 28'h310 || al_q[0] !== 8'd2) begin
      failures++;
      $display("[TB] FAIL long_next_aw: got n=%0d addr=%h len=%0d, expected 1 0000310 2", aa_q.size(), aa_q[0], al_q[0]);
    end
    assertions++;
    if (bd_q.size() != 3 || bd_q[0] !== 32'h0E00 || bd_q[2] !== 32'h0E02 || bl_q[2] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL long_next_beats: got n=%0d d0=%h d2=%h last2=%b, expected 3 00000e00 00000e02 1",
               bd_q.size(), bd_q[0], bd_q[2], bl_q[2]);
    end
  endtask

  task automatic test_drop();
    clear_queues();
    send_pkt(4'h2, 8'd3, 28'h0000400, 4, 32'h0000_0F00);
    repeat (10) @(negedge clk);
    assertions++;
    if (aa_q.size() != 0 || drop_cnt !== 16'd0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL drop_opcode: got aw=%0d drop=%0d busy=%b, expected 0 0 0", aa_q.size(), drop_cnt, busy);
    end
    stall_viol = 0;
    w_mode = 2;
    send_pkt(4'h1, 8'd3, 28'h0000500, 4, 32'h0000_0500);
    send_pkt(4'h1, 8'd1, 28'h0000600, 2, 32'h0000_0600);
    @(negedge clk);
    assertions++;
    if (drop_cnt !== 16'd1 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL drop_busy: got drop=%0d busy=%b, expected 1 1", drop_cnt, busy);
    end
    w_mode = 0;
    wait_done(100);
    assertions++;
    if (aa_q.size() != 1 || aa_q[0] !== 28'h500 || al_q[0] !== 8'd3) begin
      failures++;
      $display("[TB] FAIL drop_aw: got n=%0d addr=%h len=%0d, expected 1 0000500 3", aa_q.size(), aa_q[0], al_q[0]);
    end
    for (int i = 0; i < 4; i++) begin
      assertions++;
      if (i >= bd_q.size() || bd_q[i] !== 32'h0500 + 32'(i) || bl_q[i] !== (i == 3)) begin
        failures++;
        $display("[TB] FAIL drop_beat%0d: got data=%h last=%b, expected data=%h last=%b",
                 i, bd_q[i], bl_q[i], 32'h0500 + 32'(i), (i == 3));
      end
    end
    assertions++;
    if (bd_q.size() != 4 || stall_viol != 0) begin
      failures++;
      $display("[TB] FAIL drop_intact: got beats=%0d unstable=%0d, expected 4 0", bd_q.size(), stall_viol);
    end
  endtask

  task automatic test_reset_mid();
    clear_queues();
    w_mode = 2;
    send_pkt(4'h1, 8'd3, 28'h0000700, 4, 32'h0000_0700);
    @(negedge clk);
    assertions++;
    if (wr_data_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rst_pre_valid: got %b, expected 1", wr_data_valid);
    end
    #2 rstn = 1'b0;
    #1;
    assertions++;
    if ({wr_addr_valid, wr_data_valid, wr_data_last, busy} !== 4'b0000 || wr_strb !== 4'h0) begin
      failures++;
      $display("[TB] FAIL rst_async: got flags=%b strb=%h, expected 0000 0",
               {wr_addr_valid, wr_data_valid, wr_data_last, busy}, wr_strb);
    end
    assertions++;
    if (err_short !== 16'd0 || drop_cnt !== 16'd0) begin
      failures++;
      $display("[TB] FAIL rst_counters: got err_short=%0d drop=%0d, expected 0 0", err_short, drop_cnt);
    end
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rstn = 1'b1;
    w_mode = 0;
    clear_queues();
    send_pkt(4'h1, 8'd0, 28'h0000800, 1, 32'hDEAD_BEEF);
    wait_done(100);
    assertions++;
    if (aa_q.size() != 1 || aa_q[0] !== 28'h800 || al_q[0] !== 8'd0) begin
      failures++;
      $display("[TB] FAIL rst_new_aw: got n=%0d addr=%h len=%0d, expected 1 0000800 0", aa_q.size(), aa_q[0], al_q[0]);
    end
    assertions++;
    if (bd_q.size() != 1 || bd_q[0] !== 32'hDEAD_BEEF || bs_q[0] !== 4'hF || bl_q[0] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rst_new_beat: got n=%0d data=%h strb=%h last=%b, expected 1 deadbeef f 1",
               bd_q.size(), bd_q[0], bs_q[0], bl_q[0]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_short();
    test_long();
    test_drop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/udp_wr_burst_gen.md
# udp_wr_burst_gen

Converts UDP write-command packets, received as a 32-bit word stream, into AXI-style write bursts on the DDR slave's write address/data channels. Sits between the UDP receive path and the DDR3 slave write port, alongside the command/read logic on the same clock. It buffers payload in an internal FIFO so the UDP side is never stalled. It guarantees every issued burst completes with exactly `wr_len+1` beats.

## Interface
- FIFO_DEPTH, 256: payload FIFO depth in words; power of two, at least 256.
- WR_OPCODE, 4'h1: value of `word0[31:28]` that marks a write packet.
- gmii_rx_clk  in  1  sole clock.
- rstn  in  1  asynchronous active-low reset.
- rec_en  in  1  `udp_rx_data` valid this cycle; cannot be back-pressured.
- udp_rx_data  in  32  received word.
- rec_pkt_done  in  1  one-cycle pulse marking packet end; may coincide with the last `rec_en` or follow it.
- wr_addr  out  28  burst start address.
- wr_len  out  8  beats minus 1.
- wr_addr_valid  out  1  address valid.
- wr_addr_ready  in  1  address accepted.
- wr_data  out  32  write beat.
- wr_strb  out  4  byte enables.
- wr_data_valid  out  1  beat valid.
- wr_data_ready  in  1  beat accepted.
- wr_data_last  out  1  final beat of the burst.
- busy  out  1  high from header capture until the last beat is accepted.
- err_short  out  16  count of short packets (saturating).
- drop_cnt  out  16  count of dropped packets (saturating).

## Operation
- Packet format:
  - word0: `[31:28]` opcode, `[7:0]` LEN (beats-1).
  - word1: `[27:0]` address.
  - Then LEN+1 payload words.
- RX FSM states: RX_IDLE, RX_ADDR, RX_DATA, RX_DISCARD.
  - RX_IDLE, on `rec_en`:
    - busy=1: go to RX_DISCARD and increment drop_cnt.
    - opcode != WR_OPCODE: go to RX_DISCARD, no count.
    - Otherwise: latch LEN and go to RX_ADDR.
  - RX_ADDR, on `rec_en`: latch address, clear payload counter, set busy, go to RX_DATA.
  - RX_DATA: each `rec_en` word is pushed to the FIFO while payload count ≤ LEN. Words beyond that are discarded silently.
  - RX_DISCARD: ignore words until `rec_pkt_done`.
  - `rec_pkt_done` in any state returns the FSM to RX_IDLE.
    - In RX_DATA with count < LEN+1: record `pad_need = LEN+1-count` and increment err_short.
    - In RX_ADDR (header only, no address): no burst is issued, busy clears, err_short increments.
- TX FSM states: TX_IDLE, TX_AW, TX_W.
  - TX_AW is entered the cycle after address capture.
  - Leave TX_AW for TX_W on `wr_addr_valid & wr_addr_ready`.
  - In TX_W:
    - Beats come from the FIFO with strb 4'hF while it is non-empty.
    - Once short-packet padding is flagged and the FIFO is empty, emit zero beats with strb 4'h0 until the beat count reaches LEN+1.
    - `wr_data_last` is high on beat LEN.
    - Return to TX_IDLE and clear busy when the last beat is accepted.
  - W beats may start before the whole packet has arrived. `wr_data_valid` is low while the FIFO is empty and no padding is pending.
- FIFO: first-word-fall-through. `FIFO_DEPTH` ≥ 256 means it cannot overflow within one packet, so no full handling is required beyond an assertion.
- Counters saturate at 16'hFFFF.

## Timing
- Reset values:
  - All outputs 0.
  - FSMs in RX_IDLE and TX_IDLE.
  - FIFO empty, counters 0.
- `wr_addr`, `wr_len` and `wr_addr_valid` are registered.
  - `wr_addr_valid` rises 1 cycle after the word1 `rec_en` cycle.
  - `wr_addr` and `wr_len` are stable while valid.
- A valid output, once asserted, holds with stable data until its ready is sampled high; there is no combinational ready→valid path.
- First W beat: `wr_data_valid` can rise no earlier than the cycle after AW acceptance, and no earlier than 1 cycle after the first payload push.
- Peak throughput is 1 beat/cycle when `wr_data_ready` stays high.
- `rec_pkt_done` coinciding with a payload `rec_en`: the word is pushed first, then the short check uses the updated count.
- A packet arriving while busy (header of the next packet during drain) is dropped whole and does not disturb the current burst.
- Reset mid-burst: asynchronous clear of all state. Valids drop immediately and the FIFO is flushed.

## Test plan
- Write packet, LEN=3, addr 28'h0000100, payload 1..4, ready tied high → one AW (addr 0x100, len 3); 4 beats 1,2,3,4; last on beat 4; strb F; busy then 0.
- LEN=255 with random `wr_addr_ready`/`wr_data_ready` stalls → 256 beats in order; data stable during stalls; last only on beat 256.
- Short packet: LEN=7, 3 payload words, then `rec_pkt_done` → 8 beats (3 data, 5 zero with strb 0); err_short=1.
- Long packet: LEN=1, 5 payload words → 2 beats only; second packet afterward completes normally.
- Opcode 4'h2 packet → no AW, drop_cnt=0; write packet sent during a stalled burst → drop_cnt=1 and the first burst is intact.
- `rstn` low mid-TX_W → all valids 0 asynchronously; after release a new LEN=0 packet yields a single beat with last=1.
